// File: rtl/bemf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : bemf_sequencer
// Description : Round-robin back-EMF sampling controller. On each sample tick
//               it settles, takes a high-side and a low-side ADC reading per
//               enabled motor, issues one integrator transaction per motor
//               and writes the integrator result back into the per-motor
//               accumulators that it owns.
// Revision    : 1.0 - initial release
// ============================================================================
module bemf_sequencer #(
  parameter int SETTLE_CYCLES = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        sample_tick,
  input  logic [3:0]  mot_en,
  input  logic [3:0]  bemf_clr,
  input  logic [21:0] calib0,
  input  logic [21:0] calib1,
  input  logic [21:0] calib2,
  input  logic [21:0] calib3,
  output logic        adc_req,
  output logic [2:0]  adc_chan,
  input  logic        adc_done,
  input  logic [9:0]  adc_data,
  output logic [9:0]  bemf_adc_h,
  output logic [9:0]  bemf_adc_l,
  output logic [1:0]  mot_sel_in,
  output logic        in_valid,
  output logic [21:0] bemf_in,
  output logic [21:0] bemf_calib_in,
  input  logic [21:0] bemf_out,
  input  logic [1:0]  mot_sel_out,
  input  logic        out_valid,
  output logic [21:0] bemf0,
  output logic [21:0] bemf1,
  output logic [21:0] bemf2,
  output logic [21:0] bemf3,
  output logic        round_done,
  output logic        overrun
);

  localparam int CNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SETTLE   = 3'd1,
    REQ_H    = 3'd2,
    REQ_L    = 3'd3,
    ISSUE    = 3'd4,
    WAIT_RES = 3'd5,
    NEXT     = 3'd6
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        m_q, m_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              adc_req_q, adc_req_d;
  logic [2:0]        adc_chan_q, adc_chan_d;
  logic [9:0]        adc_h_q, adc_h_d;
  logic [9:0]        adc_l_q, adc_l_d;
  logic              in_valid_q, in_valid_d;
  logic [1:0]        mot_sel_in_q, mot_sel_in_d;
  logic [21:0]       bemf_in_q, bemf_in_d;
  logic [21:0]       calib_in_q, calib_in_d;
  logic [21:0]       bemf_q [4];
  logic [21:0]       bemf_d [4];
  logic              clear_pend_q, clear_pend_d;
  logic              round_done_q, round_done_d;
  logic              overrun_q, overrun_d;

  logic [21:0]       calib_sel [4];
  logic [1:0]        first_en;
  logic              any_en;
  logic [1:0]        nxt_en;
  logic              has_nxt;
  logic              discard_wb;

  assign calib_sel[0] = calib0;
  assign calib_sel[1] = calib1;
  assign calib_sel[2] = calib2;
  assign calib_sel[3] = calib3;

  // Find the lowest enabled motor and the nearest enabled motor above m.
  always_comb begin
    first_en = 2'd0;
    any_en   = 1'b0;
    nxt_en   = 2'd0;
    has_nxt  = 1'b0;
    for (int i = 3; i >= 0; i--) begin
      if (mot_en[i]) begin
        first_en = 2'(i);
        any_en   = 1'b1;
        if (2'(i) > m_q) begin
          nxt_en  = 2'(i);
          has_nxt = 1'b1;
        end
      end
    end
  end

  // Sequencer next-state logic: settle, two conversions, issue, wait, advance.
  always_comb begin
    state_d      = state_q;
    m_d          = m_q;
    cnt_d        = cnt_q;
    round_done_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (sample_tick) begin
          state_d = SETTLE;
          cnt_d   = SETTLE_LOAD;
          m_d     = 2'd0;
        end
      end
      SETTLE: begin
        if (cnt_q == '0) begin
          // Disabled motors are skipped before any conversion is requested.
          if (any_en) begin
            m_d     = first_en;
            state_d = REQ_H;
          end else begin
            state_d = NEXT;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      REQ_H: if (adc_done) state_d = REQ_L;
      REQ_L: if (adc_done) state_d = ISSUE;
      ISSUE: state_d = WAIT_RES;
      WAIT_RES: if (out_valid) state_d = NEXT;
      NEXT: begin
        if (has_nxt) begin
          m_d     = nxt_en;
          state_d = REQ_H;
        end else begin
          round_done_d = 1'b1;
          state_d      = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: ADC handshake, sample capture, integrator launch, write-back.
  always_comb begin
    // A clear landing between ISSUE and the result must not be overwritten
    // by the sum that was launched from the pre-clear value.
    discard_wb = out_valid && clear_pend_q && (mot_sel_out == m_q);

    for (int k = 0; k < 4; k++) begin
      bemf_d[k] = bemf_q[k];
      if (out_valid && (mot_sel_out == 2'(k)) && !discard_wb) bemf_d[k] = bemf_out;
      if (bemf_clr[k]) bemf_d[k] = '0;
    end

    clear_pend_d = clear_pend_q;
    if (out_valid) begin
      clear_pend_d = 1'b0;
    end else if (((state_q == ISSUE) || (state_q == WAIT_RES)) && bemf_clr[m_q]) begin
      clear_pend_d = 1'b1;
    end

    adc_req_d  = (state_d == REQ_H) || (state_d == REQ_L);
    adc_chan_d = adc_chan_q;
    if (adc_req_d) adc_chan_d = {m_d, (state_d == REQ_L)};

    adc_h_d = adc_h_q;
    adc_l_d = adc_l_q;
    if ((state_q == REQ_H) && adc_done) adc_h_d = adc_data;
    if ((state_q == REQ_L) && adc_done) adc_l_d = adc_data;

    // Integrator inputs only move on the clock that enters ISSUE.
    in_valid_d   = (state_d == ISSUE);
    mot_sel_in_d = mot_sel_in_q;
    bemf_in_d    = bemf_in_q;
    calib_in_d   = calib_in_q;
    if (in_valid_d) begin
      mot_sel_in_d = m_d;
      bemf_in_d    = bemf_d[m_d];
      calib_in_d   = calib_sel[m_d];
    end

    overrun_d = sample_tick && (state_q != IDLE);
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      m_q          <= 2'd0;
      cnt_q        <= '0;
      adc_req_q    <= 1'b0;
      adc_chan_q   <= 3'd0;
      adc_h_q      <= 10'd0;
      adc_l_q      <= 10'd0;
      in_valid_q   <= 1'b0;
      mot_sel_in_q <= 2'd0;
      bemf_in_q    <= 22'd0;
      calib_in_q   <= 22'd0;
      for (int k = 0; k < 4; k++) bemf_q[k] <= 22'd0;
      clear_pend_q <= 1'b0;
      round_done_q <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      m_q          <= m_d;
      cnt_q        <= cnt_d;
      adc_req_q    <= adc_req_d;
      adc_chan_q   <= adc_chan_d;
      adc_h_q      <= adc_h_d;
      adc_l_q      <= adc_l_d;
      in_valid_q   <= in_valid_d;
      mot_sel_in_q <= mot_sel_in_d;
      bemf_in_q    <= bemf_in_d;
      calib_in_q   <= calib_in_d;
      for (int k = 0; k < 4; k++) bemf_q[k] <= bemf_d[k];
      clear_pend_q <= clear_pend_d;
      round_done_q <= round_done_d;
      overrun_q    <= overrun_d;
    end
  end

  assign adc_req       = adc_req_q;
  assign adc_chan      = adc_chan_q;
  assign bemf_adc_h    = adc_h_q;
  assign bemf_adc_l    = adc_l_q;
  assign in_valid      = in_valid_q;
  assign mot_sel_in    = mot_sel_in_q;
  assign bemf_in       = bemf_in_q;
  assign bemf_calib_in = calib_in_q;
  assign bemf0         = bemf_q[0];
  assign bemf1         = bemf_q[1];
  assign bemf2         = bemf_q[2];
  assign bemf3         = bemf_q[3];
  assign round_done    = round_done_q;
  assign overrun       = overrun_q;

endmodule
`default_nettype wire

// File: tb/tb_bemf_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_bemf_sequencer
// Description : Scoreboard bench for bemf_sequencer with an ADC model and a
//               4-clock integrator model (result = acc + h - l - calib).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bemf_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        sample_tick;
  logic [3:0]  mot_en;
  logic [3:0]  bemf_clr;
  logic [21:0] cal [4];
  logic        adc_req;
  logic [2:0]  adc_chan;
  logic        adc_done;
  logic [9:0]  adc_data;
  logic [9:0]  bemf_adc_h, bemf_adc_l;
  logic [1:0]  mot_sel_in;
  logic        in_valid;
  logic [21:0] bemf_in, bemf_calib_in;
  logic [21:0] bemf_out;
  logic [1:0]  mot_sel_out;
  logic        out_valid;
  logic [21:0] bemf0, bemf1, bemf2, bemf3;
  logic        round_done, overrun;

  always #5 clk = ~clk;

  bemf_sequencer #(.SETTLE_CYCLES(16)) dut (
    .clk(clk), .rst(rst), .sample_tick(sample_tick), .mot_en(mot_en),
    .bemf_clr(bemf_clr), .calib0(cal[0]), .calib1(cal[1]), .calib2(cal[2]),
    .calib3(cal[3]), .adc_req(adc_req), .adc_chan(adc_chan),
    .adc_done(adc_done), .adc_data(adc_data), .bemf_adc_h(bemf_adc_h),
    .bemf_adc_l(bemf_adc_l), .mot_sel_in(mot_sel_in), .in_valid(in_valid),
    .bemf_in(bemf_in), .bemf_calib_in(bemf_calib_in), .bemf_out(bemf_out),
    .mot_sel_out(mot_sel_out), .out_valid(out_valid), .bemf0(bemf0),
    .bemf1(bemf1), .bemf2(bemf2), .bemf3(bemf3), .round_done(round_done),
    .overrun(overrun)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [21:0] calib;
    logic [21:0] acc;
    logic [9:0]  h;
    logic [9:0]  l;
  } tx_t;

  typedef struct packed {
    logic [21:0] b0;
    logic [21:0] b1;
    logic [21:0] b2;
    logic [21:0] b3;
  } rnd_t;

  int          q_chan[$];
  tx_t         q_tx[$];
  rnd_t        q_round[$];
  int          total = 0;
  int          bad = 0;
  int          rounds_seen = 0;
  int          ovr_seen = 0;
  logic [9:0]  adc_val [8];
  int          dly [8];
  logic [21:0] acc_model [4];
  int          adc_cnt;
  logic        pv [5];
  logic [1:0]  ps [5];
  logic [21:0] pr [5];
  tx_t         mon_tx;
  rnd_t        mon_rnd;
  int          s, n, ovr0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  task automatic fail_evt(input string name, input logic [31:0] act);
    total++;
    bad++;
    $display("FAIL %s: got event with value 0x%0h, want no event", name, act);
  endtask

  // Queue the expected ADC channels, integrator transactions and round-end
  // accumulator values; discard[m] models a clear during m's transaction.
  task automatic push_round(input logic [3:0] en, input logic [3:0] discard);
    tx_t  t;
    rnd_t r;
    for (int m = 0; m < 4; m++) begin
      if (en[m]) begin
        q_chan.push_back(2 * m);
        q_chan.push_back(2 * m + 1);
        t.sel   = 2'(m);
        t.calib = cal[m];
        t.acc   = acc_model[m];
        t.h     = adc_val[2*m];
        t.l     = adc_val[2*m+1];
        q_tx.push_back(t);
        acc_model[m] = acc_model[m] + 22'(adc_val[2*m]) - 22'(adc_val[2*m+1]) - cal[m];
        if (discard[m]) acc_model[m] = 22'd0;
      end
    end
    r = {acc_model[0], acc_model[1], acc_model[2], acc_model[3]};
    q_round.push_back(r);
  endtask

  task automatic tick();
    @(posedge clk); #1 sample_tick = 1'b1;
    @(posedge clk); #1 sample_tick = 1'b0;
  endtask

  task automatic clear_all();
    @(posedge clk); #1 bemf_clr = 4'hF;
    @(posedge clk); #1 bemf_clr = 4'h0;
    for (int m = 0; m < 4; m++) acc_model[m] = 22'd0;
  endtask

  task automatic wait_round(input string name, input int start);
    int k;
    k = 0;
    while (rounds_seen == start && k < 1000) begin
      @(posedge clk);
      k++;
    end
    chk(name, 32'(rounds_seen - start), 32'd1);
  endtask

  // ADC model: answers a request after dly[chan] extra cycles.
  initial begin
    adc_done = 1'b0;
    adc_data = 10'd0;
    adc_cnt  = 0;
    forever begin
      @(posedge clk); #1;
      if (rst || !adc_req) begin
        adc_cnt  = 0;
        adc_done = 1'b0;
      end else if (adc_cnt >= dly[adc_chan]) begin
        adc_done = 1'b1;
        adc_data = adc_val[adc_chan];
        adc_cnt  = 0;
      end else begin
        adc_done = 1'b0;
        adc_cnt++;
      end
    end
  end

  // Integrator model: result appears 4 clocks after in_valid.
  initial begin
    out_valid   = 1'b0;
    mot_sel_out = 2'd0;
    bemf_out    = 22'd0;
    for (int i = 0; i < 5; i++) begin
      pv[i] = 1'b0; ps[i] = 2'd0; pr[i] = 22'd0;
    end
    forever begin
      @(posedge clk); #1;
      for (int i = 4; i > 0; i--) begin
        pv[i] = pv[i-1]; ps[i] = ps[i-1]; pr[i] = pr[i-1];
      end
      pv[0] = in_valid;
      ps[0] = mot_sel_in;
      pr[0] = bemf_in + 22'(bemf_adc_h) - 22'(bemf_adc_l) - bemf_calib_in;
      out_valid   = pv[4];
      mot_sel_out = ps[4];
      bemf_out    = pr[4];
    end
  end

  // Monitor: pops the scoreboard whenever the DUT presents an event.
  initial begin
    forever begin
      @(negedge clk);
      if (adc_req) begin
        if (q_chan.size() == 0) begin
          fail_evt("adc_req_unexpected", 32'(adc_chan));
        end else begin
          chk("adc_chan", 32'(adc_chan), 32'(q_chan[0]));
          if (adc_done) void'(q_chan.pop_front());
        end
      end
      if (in_valid) begin
        if (q_tx.size() == 0) begin
          fail_evt("in_valid_unexpected", 32'(mot_sel_in));
        end else begin
          mon_tx = q_tx.pop_front();
          chk("mot_sel_in", 32'(mot_sel_in), 32'(mon_tx.sel));
          chk("bemf_calib_in", 32'(bemf_calib_in), 32'(mon_tx.calib));
          chk("bemf_in", 32'(bemf_in), 32'(mon_tx.acc));
          chk("bemf_adc_h", 32'(bemf_adc_h), 32'(mon_tx.h));
          chk("bemf_adc_l", 32'(bemf_adc_l), 32'(mon_tx.l));
        end
      end
      if (round_done) begin
        rounds_seen++;
        if (q_round.size() == 0) begin
          fail_evt("round_done_unexpected", 32'(bemf0));
        end else begin
          mon_rnd = q_round.pop_front();
          chk("round_bemf0", 32'(bemf0), 32'(mon_rnd.b0));
          chk("round_bemf1", 32'(bemf1), 32'(mon_rnd.b1));
          chk("round_bemf2", 32'(bemf2), 32'(mon_rnd.b2));
          chk("round_bemf3", 32'(bemf3), 32'(mon_rnd.b3));
        end
      end
      if (overrun) ovr_seen++;
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    rst         = 1'b1;
    sample_tick = 1'b0;
    mot_en      = 4'h0;
    bemf_clr    = 4'h0;
    for (int m = 0; m < 4; m++) begin
      cal[m]       = 22'd0;
      acc_model[m] = 22'd0;
      adc_val[2*m]   = 10'd600;
      adc_val[2*m+1] = 10'd100;
    end
    for (int c = 0; c < 8; c++) dly[c] = 0;

    repeat (3) @(posedge clk);
    #1;
    chk("rst_adc_req", 32'(adc_req), 32'd0);
    chk("rst_adc_chan", 32'(adc_chan), 32'd0);
    chk("rst_in_valid", 32'(in_valid), 32'd0);
    chk("rst_mot_sel_in", 32'(mot_sel_in), 32'd0);
    chk("rst_adc_h", 32'(bemf_adc_h), 32'd0);
    chk("rst_adc_l", 32'(bemf_adc_l), 32'd0);
    chk("rst_bemf_in", 32'(bemf_in), 32'd0);
    chk("rst_calib_in", 32'(bemf_calib_in), 32'd0);
    chk("rst_bemf0", 32'(bemf0), 32'd0);
    chk("rst_bemf1", 32'(bemf1), 32'd0);
    chk("rst_bemf2", 32'(bemf2), 32'd0);
    chk("rst_bemf3", 32'(bemf3), 32'd0);
    chk("rst_round_done", 32'(round_done), 32'd0);
    chk("rst_overrun", 32'(overrun), 32'd0);
    rst = 1'b0;

    // Basic round, twice: 600-100 accumulates to 500 then 1000.
    mot_en = 4'hF;
    push_round(4'hF, 4'h0);
    s = rounds_seen;
    tick();
    wait_round("basic_round1_done", s);
    chk("basic_r1_bemf3", 32'(bemf3), 32'd500);
    push_round(4'hF, 4'h0);
    s = rounds_seen;
    tick();
    wait_round("basic_round2_done", s);
    chk("basic_r2_bemf0", 32'(bemf0), 32'd1000);

    // Skip motors 1 and 3.
    clear_all();
    mot_en = 4'b0101;
    push_round(4'b0101, 4'h0);
    s = rounds_seen;
    tick();
    wait_round("skip_round_done", s);
    chk("skip_bemf1", 32'(bemf1), 32'd0);
    chk("skip_bemf2", 32'(bemf2), 32'd500);

    // Nothing enabled: round still completes.
    mot_en = 4'b0000;
    push_round(4'b0000, 4'h0);
    s = rounds_seen;
    tick();
    wait_round("none_round_done", s);

    // Calibration and sign: 100 - 400 - 5 = -305.
    clear_all();
    mot_en     = 4'b0010;
    adc_val[2] = 10'd100;
    adc_val[3] = 10'd400;
    cal[1]     = 22'd5;
    push_round(4'b0010, 4'h0);
    s = rounds_seen;
    tick();
    wait_round("calib_round_done", s);
    chk("calib_bemf1", 32'(bemf1), 32'h003FFECF);
    adc_val[2] = 10'd600;
    adc_val[3] = 10'd100;
    cal[1]     = 22'd0;

    // Overrun tick and clear of motor 2 during its transaction.
    clear_all();
    mot_en = 4'hF;
    ovr0   = ovr_seen;
    push_round(4'hF, 4'b0100);
    s = rounds_seen;
    tick();
    n = 0;
    while (!(in_valid && mot_sel_in == 2'd2) && n < 500) begin
      @(posedge clk); #1;
      n++;
    end
    chk("issue_m2_reached", 32'(in_valid && mot_sel_in == 2'd2), 32'd1);
    @(posedge clk); #1;
    bemf_clr    = 4'b0100;
    sample_tick = 1'b1;
    @(posedge clk); #1;
    bemf_clr    = 4'b0000;
    sample_tick = 1'b0;
    wait_round("overrun_round_done", s);
    chk("overrun_count", 32'(ovr_seen - ovr0), 32'd1);
    chk("clear_bemf2", 32'(bemf2), 32'd0);
    chk("clear_bemf3", 32'(bemf3), 32'd500);

    // ADC wait states of 37 clocks.
    clear_all();
    mot_en = 4'b0001;
    for (int c = 0; c < 8; c++) dly[c] = 37;
    push_round(4'b0001, 4'h0);
    s = rounds_seen;
    tick();
    wait_round("wait_round_done", s);
    chk("wait_bemf0", 32'(bemf0), 32'd500);
    for (int c = 0; c < 8; c++) dly[c] = 0;

    // Asynchronous reset with the low-side conversion stalled.
    mot_en = 4'hF;
    dly[1] = 100000;
    ovr0   = ovr_seen;
    q_chan.push_back(0);
    q_chan.push_back(1);
    tick();
    n = 0;
    while (!(adc_req && adc_chan == 3'd1) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    chk("stall_reached", 32'(adc_req && adc_chan == 3'd1), 32'd1);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    chk("async_rst_adc_req", 32'(adc_req), 32'd0);
    chk("async_rst_adc_chan", 32'(adc_chan), 32'd0);
    chk("async_rst_bemf0", 32'(bemf0), 32'd0);
    @(posedge clk); #1;
    q_chan.delete();
    q_tx.delete();
    q_round.delete();
    dly[1] = 0;
    for (int m = 0; m < 4; m++) acc_model[m] = 22'd0;
    rst = 1'b0;
    push_round(4'hF, 4'h0);
    s = rounds_seen;
    tick();
    wait_round("post_rst_round_done", s);
    chk("post_rst_no_overrun", 32'(ovr_seen - ovr0), 32'd0);
    chk("post_rst_bemf1", 32'(bemf1), 32'd500);

    repeat (4) @(posedge clk);
    chk("q_chan_empty", 32'(q_chan.size()), 32'd0);
    chk("q_tx_empty", 32'(q_tx.size()), 32'd0);
    chk("q_round_empty", 32'(q_round.size()), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
